// File: rtl/qspi_ctrl_if.sv
// Request/response bus between the CPU-side bus logic and the QSPI controller.
//   master : requester (drives start and the request fields, observes status)
//   slave  : qspi_ctrl (samples the request fields with start, drives status)
// Signals:
//   start    request strobe, accepted only while the controller is idle
//   write    1 = write, 0 = read
//   cs_sel   target chip select
//   len      data bytes minus 1
//   address  24-bit byte address
//   data_in  write data, bytes [8*(len+1)-1:0] used
//   busy     transaction in progress
//   done     one-cycle completion pulse
//   data_out last read result, zero-extended
interface qspi_ctrl_if #(
  parameter int unsigned NUM_CS = 2
);
  localparam int unsigned CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic            start;
  logic            write;
  logic [CS_W-1:0] cs_sel;
  logic [1:0]      len;
  logic [23:0]     address;
  logic [31:0]     data_in;
  logic            busy;
  logic            done;
  logic [31:0]     data_out;

  modport master (
    output start, write, cs_sel, len, address, data_in,
    input  busy, done, data_out
  );

  modport slave (
    input  start, write, cs_sel, len, address, data_in,
    output busy, done, data_out
  );
endinterface

// File: rtl/qspi_ctrl.sv
// Quad-SPI master: one command/address/dummy/data transaction per start, all phases quad.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : request/response bus (qspi_ctrl_if.slave)
//   sclk       : QSPI clock, mode 0 (idles low)
//   cs_n       : active-low chip selects, one per device
//   io_oe      : per-line output enable
//   io_out     : quad data out, forced to zero while not driving
//   io_in      : quad data in
// Each SCLK cycle is CLK_DIV clk cycles low followed by CLK_DIV clk cycles high. Output nibbles
// advance on the clk edge where sclk falls; input nibbles are captured where sclk rises.
module qspi_ctrl #(
  parameter int unsigned NUM_CS       = 2,
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned DUMMY_CYCLES = 4,
  parameter logic [7:0]  CMD_READ     = 8'hEB,
  parameter logic [7:0]  CMD_WRITE    = 8'h32
) (
  input  logic              clk,
  input  logic              rst_n,
  qspi_ctrl_if.slave        bus,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic [3:0]        io_oe,
  output logic [3:0]        io_out,
  input  logic [3:0]        io_in
);

  localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam bit               HAS_DUMMY  = (DUMMY_CYCLES > 0);
  localparam logic [3:0]       DUMMY_LAST = HAS_DUMMY ? 4'(DUMMY_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StData,
    StGap
  } state_e;

  state_e              state_q, state_d;
  logic                sclk_q, sclk_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [CS_W-1:0]     cs_sel_q, cs_sel_d;
  logic [1:0]          len_q, len_d;
  logic [63:0]         tx_q, tx_d;
  logic [31:0]         rx_q, rx_d;
  logic [31:0]         data_out_q, data_out_d;
  logic                done_q, done_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                oe_q, oe_d;

  logic                phase_end;
  logic [3:0]          last_cnt;
  state_e              next_phase;

  // Left-justify the used write bytes so the data phase always shifts out from bit 31.
  function automatic logic [31:0] align_wdata(logic [31:0] d, logic [1:0] n);
    logic [31:0] r;
    case (n)
      2'd0:    r = {d[7:0], 24'h0};
      2'd1:    r = {d[15:0], 16'h0};
      2'd2:    r = {d[23:0], 8'h0};
      default: r = d;
    endcase
    return r;
  endfunction

  // Length (in SCLK cycles, minus 1) of the current phase and the phase that follows it.
  always_comb begin
    last_cnt   = 4'd0;
    next_phase = StIdle;
    case (state_q)
      StCmd: begin
        last_cnt   = 4'd1;
        next_phase = StAddr;
      end
      StAddr: begin
        last_cnt   = 4'd5;
        next_phase = (write_q || !HAS_DUMMY) ? StData : StDummy;
      end
      StDummy: begin
        last_cnt   = DUMMY_LAST;
        next_phase = StData;
      end
      StData: begin
        last_cnt   = {1'b0, len_q, 1'b1};
        next_phase = StGap;
      end
      default: ;
    endcase
  end

  assign phase_end = (div_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    sclk_d     = sclk_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    cs_sel_d   = cs_sel_q;
    len_d      = len_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StCmd;
          sclk_d   = 1'b0;
          div_d    = '0;
          cnt_d    = 4'd0;
          write_d  = bus.write;
          cs_sel_d = bus.cs_sel;
          len_d    = bus.len;
          tx_d     = {bus.write ? CMD_WRITE : CMD_READ, bus.address,
                      align_wdata(bus.data_in, bus.len)};
          rx_d     = '0;
        end
      end

      StCmd, StAddr, StDummy, StData: begin
        if (!phase_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising SCLK edge: sample the device.
            if (state_q == StData && !write_q) begin
              rx_d = {rx_q[27:0], io_in};
            end
          end else begin
            // Falling SCLK edge: present the next nibble; dummy cycles carry none.
            if (state_q != StDummy) begin
              tx_d = {tx_q[59:0], 4'h0};
            end
            if (cnt_q == last_cnt) begin
              cnt_d   = 4'd0;
              state_d = next_phase;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end

      StGap: begin
        if (phase_end) begin
          div_d   = '0;
          state_d = StIdle;
          done_d  = 1'b1;
          if (!write_q) begin
            data_out_d = rx_q;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Chip select and output enable are registered so the pins never glitch on state decode.
  // A cs_sel outside the populated range matches no bit, so no select asserts.
  always_comb begin
    cs_n_d = '1;
    oe_d   = 1'b0;
    if (state_d inside {StCmd, StAddr, StDummy, StData}) begin
      for (int unsigned i = 0; i < NUM_CS; i++) begin
        if (cs_sel_d == CS_W'(i)) begin
          cs_n_d[i] = 1'b0;
        end
      end
    end
    if (state_d inside {StCmd, StAddr} || (state_d == StData && write_d)) begin
      oe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sclk_q     <= 1'b0;
      div_q      <= '0;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      cs_sel_q   <= '0;
      len_q      <= 2'd0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      cs_n_q     <= '1;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= sclk_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      cs_sel_q   <= cs_sel_d;
      len_q      <= len_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      oe_q       <= oe_d;
    end
  end

  assign sclk         = sclk_q;
  assign cs_n         = cs_n_q;
  assign io_oe        = {4{oe_q}};
  assign io_out       = oe_q ? tx_q[63:60] : 4'h0;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_qspi_ctrl.sv
// Bench for qspi_ctrl. Three instances cover CLK_DIV=1/DUMMY=4 (dut0), CLK_DIV=2/DUMMY=4
// (dut1) and CLK_DIV=1/DUMMY=0 with three chip selects (dut2). One instance is active at a time;
// the stimulus pushes the expected transaction, the monitor compares it when done pulses.
module tb_qspi_ctrl;

  typedef struct {
    logic [31:0] data_out;
    int          done_cyc;
    int          rises;
    int          oe_rises;
    logic [63:0] nibs;
    logic [3:0]  cs_n;
    int          gap;
  } exp_t;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  // Request stimulus, routed to the selected instance only.
  int          sel;
  logic        start_r;
  logic        req_write;
  logic [1:0]  req_cs;
  logic [1:0]  req_len;
  logic [23:0] req_addr;
  logic [31:0] req_data;

  logic [3:0] io_in;

  qspi_ctrl_if #(.NUM_CS(2)) bus0 ();
  qspi_ctrl_if #(.NUM_CS(2)) bus1 ();
  qspi_ctrl_if #(.NUM_CS(3)) bus2 ();

  logic       sclk0, sclk1, sclk2;
  logic [1:0] cs_n0, cs_n1;
  logic [2:0] cs_n2;
  logic [3:0] oe0, oe1, oe2;
  logic [3:0] out0, out1, out2;

  assign bus0.start   = start_r && (sel == 0);
  assign bus0.write   = req_write;
  assign bus0.cs_sel  = req_cs[0];
  assign bus0.len     = req_len;
  assign bus0.address = req_addr;
  assign bus0.data_in = req_data;

  assign bus1.start   = start_r && (sel == 1);
  assign bus1.write   = req_write;
  assign bus1.cs_sel  = req_cs[0];
  assign bus1.len     = req_len;
  assign bus1.address = req_addr;
  assign bus1.data_in = req_data;

  assign bus2.start   = start_r && (sel == 2);
  assign bus2.write   = req_write;
  assign bus2.cs_sel  = req_cs;
  assign bus2.len     = req_len;
  assign bus2.address = req_addr;
  assign bus2.data_in = req_data;

  qspi_ctrl #(.NUM_CS(2), .CLK_DIV(1), .DUMMY_CYCLES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .sclk(sclk0), .cs_n(cs_n0),
    .io_oe(oe0), .io_out(out0), .io_in(io_in)
  );

  qspi_ctrl #(.NUM_CS(2), .CLK_DIV(2), .DUMMY_CYCLES(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .sclk(sclk1), .cs_n(cs_n1),
    .io_oe(oe1), .io_out(out1), .io_in(io_in)
  );

  qspi_ctrl #(.NUM_CS(3), .CLK_DIV(1), .DUMMY_CYCLES(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .sclk(sclk2), .cs_n(cs_n2),
    .io_oe(oe2), .io_out(out2), .io_in(io_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signals of the active instance; cs_n padded with 1s to 4 bits.
  logic        m_sclk, m_busy, m_done;
  logic [3:0]  m_cs, m_oe, m_out;
  logic [31:0] m_data;
  int          div_sel, dum_sel;

  always_comb begin
    case (sel)
      1: begin
        m_sclk = sclk1; m_cs = {2'b11, cs_n1}; m_oe = oe1; m_out = out1;
        m_busy = bus1.busy; m_done = bus1.done; m_data = bus1.data_out;
      end
      2: begin
        m_sclk = sclk2; m_cs = {1'b1, cs_n2}; m_oe = oe2; m_out = out2;
        m_busy = bus2.busy; m_done = bus2.done; m_data = bus2.data_out;
      end
      default: begin
        m_sclk = sclk0; m_cs = {2'b11, cs_n0}; m_oe = oe0; m_out = out0;
        m_busy = bus0.busy; m_done = bus0.done; m_data = bus0.data_out;
      end
    endcase
  end

  assign div_sel = (sel == 1) ? 2 : 1;
  assign dum_sel = (sel == 2) ? 0 : 4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  exp_t        exp_q[$];
  exp_t        ex_m;
  logic        m_act, prev_busy, prev_sclk;
  int          cyc, rises, oe_rises, run, gap, cs_bad, phase_bad, out_bad, done_cnt;
  logic [63:0] nibs;

  // Device model: data-phase nibbles count 1,2,3,...; anything earlier reads as F.
  assign io_in = (rises >= 8 + dum_sel) ? 4'(rises - 7 - dum_sel) : 4'hF;

  initial begin
    m_act = 0; prev_busy = 0; prev_sclk = 0; cyc = 0; rises = 0; oe_rises = 0; run = 0;
    gap = 0; cs_bad = 0; phase_bad = 0; out_bad = 0; done_cnt = 0; nibs = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 0; prev_busy = 0; prev_sclk = 0; rises = 0;
    end else begin
      if (m_busy && !prev_busy) begin
        m_act = 1; cyc = 1; rises = 0; oe_rises = 0; nibs = '0; run = 1; gap = 0;
        cs_bad = 0; phase_bad = 0;
      end else if (m_act) begin
        cyc++;
        if (m_sclk != prev_sclk) begin
          if (run != div_sel) phase_bad++;
          run = 1;
        end else begin
          run++;
        end
      end
      if (m_act && m_sclk && !prev_sclk) begin
        rises++;
        if (m_oe == 4'hF) begin
          oe_rises++;
          nibs = {nibs[59:0], m_out};
        end
        if (exp_q.size() > 0 && m_cs != exp_q[0].cs_n) cs_bad++;
      end
      if (m_act && m_busy) gap = (!m_sclk && m_cs == 4'hF) ? gap + 1 : 0;
      if ((m_oe == 4'h0 && m_out != 4'h0) || (m_oe != 4'h0 && m_oe != 4'hF)) out_bad++;
      if (m_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          ex_m = exp_q.pop_front();
          chk("done_cycle", cyc, ex_m.done_cyc);
          chk("sclk_cycles", rises, ex_m.rises);
          chk("driven_cycles", oe_rises, ex_m.oe_rises);
          chk("io_out_nibbles", nibs, ex_m.nibs);
          chk("data_out", m_data, ex_m.data_out);
          chk("gap_cycles", gap, ex_m.gap);
          chk("cs_n_during_xfer", cs_bad, 0);
          chk("sclk_phase_len", phase_bad, 0);
          chk("io_out_idle_zero", out_bad, 0);
          chk("busy_low_at_done", m_busy, 0);
        end
        m_act = 0;
      end
      prev_busy = m_busy;
      prev_sclk = m_sclk;
    end
  end

  task automatic launch(input int s, input logic wr, input logic [1:0] cs, input logic [1:0] ln,
                        input logic [23:0] addr, input logic [31:0] din);
    sel = s; req_write = wr; req_cs = cs; req_len = ln; req_addr = addr; req_data = din;
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    chk("accept_busy", m_busy, 1);
  endtask

  task automatic issue(input int s, input logic wr, input logic [1:0] cs, input logic [1:0] ln,
                       input logic [23:0] addr, input logic [31:0] din, input logic [31:0] e_data,
                       input int e_done, input int e_rises, input int e_oe,
                       input logic [63:0] e_nibs, input logic [3:0] e_cs, input int e_gap);
    exp_t ex;
    ex.data_out = e_data; ex.done_cyc = e_done; ex.rises = e_rises; ex.oe_rises = e_oe;
    ex.nibs = e_nibs; ex.cs_n = e_cs; ex.gap = e_gap;
    exp_q.push_back(ex);
    launch(s, wr, cs, ln, addr, din);
  endtask

  // Returns at negedge+1 of the done cycle.
  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (m_done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  int done_before;

  initial begin
    checks = 0; failures = 0;
    sel = 0; start_r = 0; req_write = 0; req_cs = 0; req_len = 0; req_addr = '0; req_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sclk", sclk0, 0);
    chk("rst_cs_n", cs_n0, 2'b11);
    chk("rst_io_oe", oe0, 0);
    chk("rst_io_out", out0, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_data_out", bus0.data_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Read 4 bytes; a start pulse mid-transaction with other fields must be ignored.
    issue(0, 0, 0, 3, 24'h123456, 32'h0, 32'h12345678, 42, 20, 8, 64'hEB123456, 4'hE, 1);
    repeat (10) @(posedge clk);
    #1;
    req_write = 1; req_len = 0; req_addr = 24'h000000; start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    wait_done("t1");
    // Back-to-back write launched in the done cycle, cs_sel=1, data_out unchanged.
    issue(0, 1, 1, 0, 24'hABCDEF, 32'hFFFF_FFA5, 32'h12345678, 22, 10, 10, 64'h32ABCDEFA5,
          4'hD, 1);
    wait_done("t2");
    @(posedge clk); #1;
    // One-byte read: dummy-cycle samples (F) must not reach data_out.
    issue(0, 0, 0, 0, 24'h000010, 32'h0, 32'h00000012, 30, 14, 8, 64'hEB000010, 4'hE, 1);
    wait_done("t3");
    @(posedge clk); #1;
    // Three-byte write: only data_in[23:0] goes out, MSB nibble first.
    issue(0, 1, 0, 2, 24'h000001, 32'hAA112233, 32'h00000012, 30, 14, 14,
          64'h32000001112233, 4'hE, 1);
    wait_done("t4");
    @(posedge clk); #1;
    // CLK_DIV=2 write: 2-cycle SCLK phases, 2-cycle gap, busy 42.
    issue(1, 1, 0, 0, 24'h00FF00, 32'h0000005A, 32'h0, 43, 10, 10, 64'h3200FF005A, 4'hE, 2);
    wait_done("t5");
    @(posedge clk); #1;
    // No dummy cycles, cs_sel=2 of 3: N=12, busy 25.
    issue(2, 0, 2, 1, 24'h654321, 32'h0, 32'h00001234, 26, 12, 8, 64'hEB654321, 4'hB, 1);
    wait_done("t6");
    @(posedge clk); #1;
    // cs_sel=3 on a 3-select part: nothing asserts, timing and data still run.
    issue(2, 0, 3, 1, 24'h000000, 32'h0, 32'h00001234, 26, 12, 8, 64'hEB000000, 4'hF, 1);
    wait_done("t7");
    @(posedge clk); #1;

    // Reset during the data phase of a read: immediate reset values, no done.
    done_before = done_cnt;
    launch(0, 0, 0, 3, 24'h123456, 32'h0);
    repeat (29) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_sclk", sclk0, 0);
    chk("midrst_cs_n", cs_n0, 2'b11);
    chk("midrst_io_oe", oe0, 0);
    chk("midrst_io_out", out0, 0);
    chk("midrst_busy", bus0.busy, 0);
    chk("midrst_done", bus0.done, 0);
    chk("midrst_data_out", bus0.data_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt, done_before);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
